// File: rtl/comparator_pkg.sv
// Shared types and constants for the chunked magnitude comparator.
// The result encoding is the {gt,lt,eq} bus, exactly one-hot once valid.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COMPARE = 2'b01,
    DONE    = 2'b10
  } state_e;

  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_LT = 3'b010;
  localparam logic [2:0] RES_EQ = 3'b001;

endpackage

// File: rtl/serial_comparator_chunk_compare.sv
// Unsigned magnitude compare of a single CHUNK-bit slice.
// Purely combinational; the parent selects which slice is presented.
module chunk_compare #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] ca,
  input  logic [CHUNK-1:0] cb,
  output logic             c_gt,
  output logic             c_lt
);

  assign c_gt = (ca > cb);
  assign c_lt = (ca < cb);

endmodule

// File: rtl/serial_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per clock from the MSB down.
// Signed operands are stored offset-binary so every chunk compare stays unsigned.
module serial_comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

  if (((WIDTH % CHUNK) != 0) || (WIDTH < CHUNK) || (CHUNK < 1)) begin : g_param_check
    $error("serial_comparator: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [2:0]       res_q, res_d;

  logic [WIDTH-1:0] flip_s, cap_a_s, cap_b_s;
  logic [CHUNK-1:0] ca_s, cb_s;
  logic             c_gt_s, c_lt_s;

  // Offset-binary conversion applied at capture time
  always_comb begin
    flip_s            = '0;
    flip_s[WIDTH-1]   = signed_mode;
    cap_a_s           = a ^ flip_s;
    cap_b_s           = b ^ flip_s;
  end

  // Select the chunk under comparison
  always_comb begin
    ca_s = a_q[idx_q*CHUNK +: CHUNK];
    cb_s = b_q[idx_q*CHUNK +: CHUNK];
  end

  chunk_compare #(.CHUNK(CHUNK)) u_chunk_compare (
    .ca   (ca_s),
    .cb   (cb_s),
    .c_gt (c_gt_s),
    .c_lt (c_lt_s)
  );

  // Next-state, capture and registered-output logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    res_d   = res_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = cap_a_s;
          b_d     = cap_b_s;
          idx_d   = IDX_TOP;
          busy_d  = 1'b1;
          state_d = COMPARE;
        end else begin
          state_d = IDLE;
        end
      end
      COMPARE: begin
        if (c_gt_s) begin
          res_d   = RES_GT;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (c_lt_s) begin
          res_d   = RES_LT;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (idx_q == '0) begin
          res_d   = RES_EQ;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d   = idx_q - IDXW'(1);
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign {gt, lt, eq} = res_q;

endmodule

// File: tb/tb_serial_comparator.sv
// Self-checking bench: spec-level reference model (signed/unsigned arithmetic plus
// latency from the highest differing bit), per-cycle compare, and literal directed cases.
module tb_serial_comparator;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             start = 1'b0;
  logic             signed_mode = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, gt, lt, eq;

  int n_tests = 0;
  int n_fail  = 0;

  serial_comparator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .gt          (gt),
    .lt          (lt),
    .eq          (eq)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] exp_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                         input logic s);
    if (s) begin
      if ($signed(x) > $signed(y)) return 3'b100;
      else if ($signed(x) < $signed(y)) return 3'b010;
      else return 3'b001;
    end else begin
      if (x > y) return 3'b100;
      else if (x < y) return 3'b010;
      else return 3'b001;
    end
  endfunction

  // Chunks examined before a decision: the chunk holding the highest differing bit.
  function automatic int exp_k(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] d;
    int p;
    d = x ^ y;
    if (d == '0) return NCHUNK;
    p = 0;
    for (int i = 0; i < WIDTH; i++) if (d[i]) p = i;
    return (WIDTH - 1 - p) / CHUNK + 1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference model: cycles left busy, done pulse, pending and held results
  int         m_left = 0;
  logic       m_done = 1'b0;
  logic [2:0] m_res  = 3'b000;
  logic [2:0] m_pend = 3'b000;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_res  <= 3'b000;
      m_pend <= 3'b000;
    end else begin
      m_done <= (m_left == 1);
      if (m_left == 1) m_res <= m_pend;
      if (m_left > 0) begin
        m_left <= m_left - 1;
      end else if (start) begin
        m_left <= exp_k(a, b);
        m_pend <= exp_res(a, b, signed_mode);
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    check("model {busy,done,gt,lt,eq}", {27'd0, busy, done, gt, lt, eq},
          {27'd0, (m_left > 0), m_done, m_res});
  end

  task automatic directed(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic ts, input logic [2:0] eres, input int ecyc,
                          input string nm);
    int cyc;
    @(posedge clk); #2;
    a = ta; b = tb; signed_mode = ts; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #2;
      cyc++;
    end
    check({nm, " done cycle"}, cyc, ecyc);
    check({nm, " result"}, {29'd0, gt, lt, eq}, {29'd0, eres});
  endtask

  task automatic idle_cycles(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
    end
  endtask

  initial begin
    int cyc;
    logic [WIDTH-1:0] ra;
    n_rst = 1'b0;
    #23;
    check("reset outputs", {27'd0, busy, done, gt, lt, eq}, 32'd0);
    n_rst = 1'b1;
    idle_cycles(2);

    directed(16'h1234, 16'h1234, 1'b0, 3'b001, 5, "unsigned equal");
    idle_cycles(2);
    directed(16'h8000, 16'h7FFF, 1'b0, 3'b100, 2, "early exit unsigned");
    idle_cycles(1);
    directed(16'h8000, 16'h7FFF, 1'b1, 3'b010, 2, "early exit signed");
    idle_cycles(1);
    directed(16'h00F1, 16'h00F2, 1'b0, 3'b010, 5, "last chunk");
    idle_cycles(1);
    directed(16'hFFFF, 16'h0001, 1'b1, 3'b010, 2, "signed -1 vs 1");
    idle_cycles(1);

    // Start during COMPARE is ignored
    @(posedge clk); #2;
    a = 16'h00F1; b = 16'h00F2; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    @(posedge clk); #2; a = 16'h0001; b = 16'h0002; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    cyc = 3;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #2;
      cyc++;
    end
    check("ignored start done cycle", cyc, 5);
    check("ignored start result", {29'd0, gt, lt, eq}, 32'd2);

    // Back-to-back: start during DONE goes straight to COMPARE
    a = 16'h8000; b = 16'h7FFF; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    check("b2b busy", {30'd0, busy, done}, 32'd2);
    check("b2b held result", {29'd0, gt, lt, eq}, 32'd2);
    @(posedge clk); #2;
    check("b2b done gt", {28'd0, done, gt, lt, eq}, 32'hC);

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      check("result hold", {28'd0, done, gt, lt, eq}, 32'h4);
    end

    // Reset during cycle 2 of an equal compare
    @(posedge clk); #2;
    a = 16'h1234; b = 16'h1234; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    @(posedge clk); #3;
    n_rst = 1'b0;
    #1;
    check("reset mid-op", {27'd0, busy, done, gt, lt, eq}, 32'd0);
    @(posedge clk); #2;
    n_rst = 1'b1;
    directed(16'h0005, 16'h0003, 1'b0, 3'b100, 5, "after reset");

    // Randomized traffic, checked by the per-cycle model compare
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      ra          = WIDTH'($urandom);
      a           = ra;
      signed_mode = 1'($urandom_range(0, 1));
      start       = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       b = ra;
        1:       b = ra ^ (WIDTH'($urandom_range(1, 15)) << (CHUNK * $urandom_range(0, NCHUNK - 1)));
        2:       b = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
        default: b = WIDTH'($urandom);
      endcase
    end
    idle_cycles(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
